row_sum_bcast: RTL and testbench
================================

Name: row_sum_bcast

Overview:
- Softmax normalisation front-end. Sits directly upstream of the integer divider stage.
- Accepts one softmax row as ROW_BEATS vectors of IN_NUM unsigned exponent values and accumulates their total.
- Replays the buffered row as dividend beats. Each beat is paired with a divisor beat that carries the row sum replicated across all lanes.

Parameters:
- IN_NUM, 8, lanes per beat.
- DATA_WIDTH, 8, unsigned element width (dividend width).
- ROW_BEATS, 4, beats per row (>=1); also the buffer depth.
- SUM_WIDTH, DATA_WIDTH+$clog2(IN_NUM*ROW_BEATS), divisor width; sized so the sum can never overflow.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high; asserted at any time it clears all state.
- data_in  in  [DATA_WIDTH-1:0] x IN_NUM (unpacked)  input row beat.
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
- dividend_data  out  [DATA_WIDTH-1:0] x IN_NUM  replayed beat.
- dividend_data_valid  out  1.
- dividend_data_ready  in  1.
- divisor_data  out  [SUM_WIDTH-1:0] x IN_NUM  row sum, replicated per lane.
- divisor_data_valid  out  1.
- divisor_data_ready  in  1.

Behaviour:
- Interface is fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: data_in_ready=1, both out valids=0, sum=0, beat counters=0, taken flags=0, state=ACCUM. Data outputs are don't-care while their valid is low.
- ACCUM state:
  - data_in_ready=1.
  - On data_in_valid&&data_in_ready: write the beat to buffer[wr_cnt]; sum += zero-extended sum of all IN_NUM lanes (combinational adder tree).
  - wr_cnt increments per accepted beat. When the accept occurs with wr_cnt==ROW_BEATS-1: wr_cnt->0, go to DRAIN.
- DRAIN state:
  - data_in_ready=0. The input is back-pressured and no overlap of rows is allowed.
  - dividend_data=buffer[rd_cnt].
  - divisor_data[i] = (sum==0) ? 1 : sum, for every lane i. Divide-by-zero guard.
- Fork handshake (DRAIN only):
  - Flags div_taken and dvs_taken record outputs already consumed for the current beat.
  - dividend_data_valid = !div_taken; divisor_data_valid = !dvs_taken.
  - A beat completes when (div_taken || dividend handshake) && (dvs_taken || divisor handshake), including both in the same cycle.
  - On completion: clear both flags; rd_cnt++.
  - If rd_cnt was ROW_BEATS-1: rd_cnt->0, sum->0, go to ACCUM. Both valids are low in the following cycle.
  - Otherwise, on a handshake without completion, set the respective flag.
- Latency: last input beat accepted at cycle t -> first output beat valid at t+1. Minimum row period = 2*ROW_BEATS cycles.
- Output data/valid are stable while valid&&!ready (AXI-style). Valid never drops without a handshake except on reset.
- Reset mid-row (ACCUM or DRAIN): the partial row is discarded; no output is emitted for it.
- ROW_BEATS==1: every accepted beat toggles ACCUM->DRAIN->ACCUM.

Decomposition:
- Shared package mx_attn_pkg:
  - enum row_state_t {ACCUM, DRAIN}.
  - Function clog2-based sum_width(IN_NUM, DATA_WIDTH, ROW_BEATS).
- One sub-module, row_buffer:
  - ROW_BEATS x IN_NUM x DATA_WIDTH register array.
  - Write port (en, addr, data); combinational read port (addr -> data).
  - No reset on storage.
- FSM, counters, adder tree and fork flags live in the top module.

Test Plan:
1. Basic row: IN_NUM=8, ROW_BEATS=4, all lanes =10, outputs always ready -> 4 dividend beats of 10s, each paired with divisor 320; first output valid one cycle after the 4th input accept.
2. Zero row: all inputs 0 -> divisor lanes read 1; dividends 0; FSM returns to ACCUM after 4 beats.
3. Max values: all lanes 255 -> divisor 8160 (fits SUM_WIDTH=13), no wrap; next row lanes =1 -> divisor 32, proving sum clears.
4. Skewed readiness: divisor_data_ready low for 3 cycles while dividend ready -> dividend valid drops after its handshake, divisor holds stable; rd_cnt advances only after divisor accepts; no beat is duplicated or lost.
5. Back-pressure: data_in_valid held high during DRAIN -> data_in_ready=0; no buffer write; sum unchanged until return to ACCUM.
6. Reset mid-DRAIN: assert rst after 2 output beats -> valids fall immediately (async); after release data_in_ready=1, and the next full row of 5s gives divisor 160.

Source files
------------

// File: rtl/mx_attn_pkg.sv
// Shared types and sizing helpers for the attention softmax datapath.
//   row_state_t : row FSM states (ACCUM collects a row, DRAIN replays it)
//   sum_width() : bit width that holds the sum of a full row without overflow
package mx_attn_pkg;

    typedef enum logic {ACCUM, DRAIN} row_state_t;

    function automatic int unsigned sum_width(input int unsigned in_num,
                                              input int unsigned data_width,
                                              input int unsigned row_beats);
        return data_width + $clog2(in_num * row_beats);
    endfunction

endpackage

// File: rtl/row_buffer.sv
// Row storage: DEPTH beats of LANES x WIDTH elements.
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : beat index to write
//   wr_data : beat to write
//   rd_addr : beat index to read
//   rd_data : combinational read data
// Storage has no reset; contents are only read after being written.
module row_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LANES  = 8,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data [LANES],
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data [LANES]
);

    logic [WIDTH-1:0] mem_q [DEPTH][LANES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                mem_q[wr_addr][i] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd_data[i] = mem_q[rd_addr][i];
        end
    end

endmodule

// File: rtl/row_sum_bcast.sv
// Softmax normalisation front-end ahead of the integer divider.
// Collects one row (ROW_BEATS beats of IN_NUM exponents), totals it, then replays
// each beat as a dividend paired with a divisor beat carrying the row sum on every lane.
//   clk, rst                                   : clock, async active-high reset
//   data_in / data_in_valid / data_in_ready    : input row beats
//   dividend_data / _valid / _ready            : replayed row beats
//   divisor_data / _valid / _ready             : row sum replicated per lane
module row_sum_bcast
    import mx_attn_pkg::*;
#(
    parameter int unsigned IN_NUM     = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROW_BEATS  = 4,
    parameter int unsigned SUM_WIDTH  = sum_width(IN_NUM, DATA_WIDTH, ROW_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] dividend_data [IN_NUM],
    output logic                  dividend_data_valid,
    input  logic                  dividend_data_ready,
    output logic [SUM_WIDTH-1:0]  divisor_data [IN_NUM],
    output logic                  divisor_data_valid,
    input  logic                  divisor_data_ready
);

    localparam int unsigned CNT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROW_BEATS - 1);

    row_state_t         state_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic [SUM_WIDTH-1:0] beat_sum;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic               div_taken_q;
    logic               dvs_taken_q;

    logic accept;
    logic div_done;
    logic dvs_done;
    logic beat_done;

    // Zero-extended lane total of the incoming beat.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            beat_sum = beat_sum + SUM_WIDTH'(data_in[i]);
        end
    end

    assign data_in_ready       = (state_q == ACCUM);
    assign accept              = data_in_valid && data_in_ready;
    assign dividend_data_valid = (state_q == DRAIN) && !div_taken_q;
    assign divisor_data_valid  = (state_q == DRAIN) && !dvs_taken_q;

    // Fork: each side may be consumed on its own cycle; the beat retires once both are.
    assign div_done  = div_taken_q || (dividend_data_valid && dividend_data_ready);
    assign dvs_done  = dvs_taken_q || (divisor_data_valid && divisor_data_ready);
    assign beat_done = (state_q == DRAIN) && div_done && dvs_done;

    // An all-zero row would divide by zero downstream; substitute 1.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            divisor_data[i] = (sum_q == '0) ? SUM_WIDTH'(1) : sum_q;
        end
    end

    row_buffer #(
        .DEPTH  (ROW_BEATS),
        .LANES  (IN_NUM),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (CNT_W)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt_q),
        .wr_data (data_in),
        .rd_addr (rd_cnt_q),
        .rd_data (dividend_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            div_taken_q <= 1'b0;
            dvs_taken_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        sum_q <= sum_q + beat_sum;
                        if (wr_cnt_q == LAST_BEAT) begin
                            wr_cnt_q <= '0;
                            state_q  <= DRAIN;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat_done) begin
                        div_taken_q <= 1'b0;
                        dvs_taken_q <= 1'b0;
                        if (rd_cnt_q == LAST_BEAT) begin
                            rd_cnt_q <= '0;
                            sum_q    <= '0;
                            state_q  <= ACCUM;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end else begin
                        if (dividend_data_valid && dividend_data_ready) div_taken_q <= 1'b1;
                        if (divisor_data_valid && divisor_data_ready)   dvs_taken_q <= 1'b1;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_row_sum_bcast.sv
module tb_row_sum_bcast;

    localparam int unsigned IN_NUM     = 8;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ROW_BEATS  = 4;
    localparam int unsigned SUM_WIDTH  = DATA_WIDTH + $clog2(IN_NUM * ROW_BEATS);

    logic                  clk;
    logic                  rst;
    logic [DATA_WIDTH-1:0] data_in [IN_NUM];
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] dividend_data [IN_NUM];
    logic                  dividend_data_valid;
    logic                  dividend_data_ready;
    logic [SUM_WIDTH-1:0]  divisor_data [IN_NUM];
    logic                  divisor_data_valid;
    logic                  divisor_data_ready;

    row_sum_bcast #(
        .IN_NUM     (IN_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_BEATS  (ROW_BEATS)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_in             (data_in),
        .data_in_valid       (data_in_valid),
        .data_in_ready       (data_in_ready),
        .dividend_data       (dividend_data),
        .dividend_data_valid (dividend_data_valid),
        .dividend_data_ready (dividend_data_ready),
        .divisor_data        (divisor_data),
        .divisor_data_valid  (divisor_data_valid),
        .divisor_data_ready  (divisor_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the row as sent, its arithmetic total, and how many
    // dividend / divisor beats the consumer has taken so far.
    logic [DATA_WIDTH-1:0] row_ref [ROW_BEATS][IN_NUM];
    int row_total;
    bit in_drain;
    int div_idx;
    int dvs_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int cur_beat();
        return (div_idx < dvs_idx) ? div_idx : dvs_idx;
    endfunction

    // Starts and ends on a falling edge.
    task automatic send_row(input int kind, input int val, input bit gaps);
        row_total = 0;
        for (int b = 0; b < ROW_BEATS; b++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                row_ref[b][i] = (kind == 0) ? 8'($urandom_range(0, 255)) : 8'(val);
                row_total += int'(row_ref[b][i]);
            end
        end
        for (int b = 0; b < ROW_BEATS; b++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    data_in_valid = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            for (int i = 0; i < IN_NUM; i++) data_in[i] = row_ref[b][i];
            data_in_valid = 1'b1;
            check("in_ready_accum", 32'(data_in_ready), 32'd1);
            check("div_valid_accum", 32'(dividend_data_valid), 32'd0);
            check("dvs_valid_accum", 32'(divisor_data_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        in_drain = 1'b1;
        div_idx = 0;
        dvs_idx = 0;
    endtask

    // mode 0: always ready, 1: random readiness, 2: divisor stalled for 3 cycles.
    task automatic drain(input int mode, input int stop_at, input bit hold_in);
        int cyc;
        int cur;
        int exp_div;
        cyc = 0;
        while (in_drain && cur_beat() < stop_at && cyc < 200) begin
            cur = cur_beat();
            case (mode)
                0: begin dividend_data_ready = 1'b1; divisor_data_ready = 1'b1; end
                1: begin
                    dividend_data_ready = 1'($urandom_range(0, 1));
                    divisor_data_ready  = 1'($urandom_range(0, 1));
                end
                default: begin
                    dividend_data_ready = 1'b1;
                    divisor_data_ready  = (cyc >= 3);
                end
            endcase
            if (hold_in) begin
                data_in_valid = 1'b1;
                for (int i = 0; i < IN_NUM; i++) data_in[i] = 8'($urandom_range(0, 255));
            end
            check("in_ready_drain", 32'(data_in_ready), 32'd0);
            check("div_valid", 32'(dividend_data_valid), 32'(div_idx == cur));
            check("dvs_valid", 32'(divisor_data_valid), 32'(dvs_idx == cur));
            if (div_idx == cur) begin
                for (int i = 0; i < IN_NUM; i++)
                    check("dividend_lane", 32'(dividend_data[i]), 32'(row_ref[cur][i]));
            end
            if (dvs_idx == cur) begin
                exp_div = (row_total == 0) ? 1 : row_total;
                for (int i = 0; i < IN_NUM; i++)
                    check("divisor_lane", 32'(divisor_data[i]), 32'(exp_div));
            end
            if (div_idx == cur && dividend_data_ready) div_idx++;
            if (dvs_idx == cur && divisor_data_ready) dvs_idx++;
            if (cur_beat() == ROW_BEATS) in_drain = 1'b0;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("drain_bound", 32'(cyc < 200), 32'd1);
        data_in_valid = 1'b0;
        if (!in_drain) begin
            check("in_ready_after_row", 32'(data_in_ready), 32'd1);
            check("div_valid_after_row", 32'(dividend_data_valid), 32'd0);
            check("dvs_valid_after_row", 32'(divisor_data_valid), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        data_in_valid = 1'b0;
        dividend_data_ready = 1'b0;
        divisor_data_ready = 1'b0;
        for (int i = 0; i < IN_NUM; i++) data_in[i] = '0;
        in_drain = 1'b0;
        div_idx = 0;
        dvs_idx = 0;
        row_total = 0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(data_in_ready), 32'd1);
        check("reset_div_valid", 32'(dividend_data_valid), 32'd0);
        check("reset_dvs_valid", 32'(divisor_data_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic row of 10s: divisor 320, first output one cycle after last accept.
        send_row(1, 10, 1'b0);
        drain(0, ROW_BEATS, 1'b0);

        // Zero row: divide-by-zero guard.
        send_row(1, 0, 1'b0);
        drain(0, ROW_BEATS, 1'b0);

        // Max values then small values: no wrap, sum clears between rows.
        send_row(1, 255, 1'b0);
        drain(0, ROW_BEATS, 1'b0);
        send_row(1, 1, 1'b0);
        drain(0, ROW_BEATS, 1'b0);

        // Divisor side stalled while dividend side keeps accepting.
        send_row(0, 0, 1'b0);
        drain(2, ROW_BEATS, 1'b0);

        // Input held valid during replay must not disturb the row or the sum.
        send_row(0, 0, 1'b0);
        drain(1, ROW_BEATS, 1'b1);
        send_row(1, 3, 1'b0);
        drain(0, ROW_BEATS, 1'b0);

        // Random rows, random gaps and random readiness.
        for (int r = 0; r < 6; r++) begin
            send_row(0, 0, 1'b1);
            drain(1, ROW_BEATS, 1'b0);
        end

        // Reset in the middle of replay.
        send_row(0, 0, 1'b0);
        drain(0, 2, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_div_valid", 32'(dividend_data_valid), 32'd0);
        check("midrst_dvs_valid", 32'(divisor_data_valid), 32'd0);
        check("midrst_in_ready", 32'(data_in_ready), 32'd1);
        in_drain = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 32'(data_in_ready), 32'd1);
        send_row(1, 5, 1'b0);
        drain(0, ROW_BEATS, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
